// File: rtl/int_priority_sched.sv
// -----------------------------------------------------------------------------
// int_priority_sched
// Picks one pending, unmasked interrupt source by programmable priority. It then
// runs the request / ack / end-of-interrupt handshake with the CPU, enforces an
// ack timeout, and pulses a clear for the source that was serviced.
//
// Build option:
//   INT_SCHED_ROUND_ROBIN_EN  -- when defined, ties at equal priority rotate via
//                                rr_ptr. When undefined, the lowest index wins a
//                                tie and there is no rr_ptr register.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | nothing in flight; waiting for any eligible source
// ARB   | latch the arbitration winner, or fall back if nothing is eligible
// REQ   | irq_out high; wait for cpu_ack or ack timeout
// SERV  | CPU owns the interrupt; wait for cpu_eoi
// -----------------------------------------------------------------------------
module int_priority_sched #(
  parameter int N_SRC  = 8,
  parameter int PRIO_W = 2,
  parameter int TO_W   = 8
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic                      sched_en_i,
  input  logic [N_SRC-1:0]          irq_src_i,
  input  logic [N_SRC-1:0]          irq_mask_i,
  input  logic [N_SRC*PRIO_W-1:0]   irq_prio_i,
  input  logic [TO_W-1:0]           timeout_val_i,
  input  logic                      cpu_ack_i,
  input  logic                      cpu_eoi_i,
  output logic                      irq_out_o,
  output logic [$clog2(N_SRC)-1:0]  irq_id_o,
  output logic [PRIO_W-1:0]         irq_lvl_o,
  output logic                      busy_o,
  output logic                      svc_done_o,
  output logic [$clog2(N_SRC)-1:0]  svc_id_o,
  output logic                      timeout_err_o
);

  localparam int ID_W = $clog2(N_SRC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_REQ  = 2'd2,
    ST_SERV = 2'd3
  } state_t;

  state_t            state_q;
  logic [TO_W-1:0]   cnt_q;
  logic              irq_out_q;
  logic [ID_W-1:0]   irq_id_q;
  logic [PRIO_W-1:0] irq_lvl_q;
  logic              busy_q;
  logic              svc_done_q;
  logic [ID_W-1:0]   svc_id_q;
  logic              timeout_err_q;

  logic [N_SRC-1:0]  elig;
  logic [ID_W-1:0]   search_base;
  logic [ID_W-1:0]   cand_id;
  logic [PRIO_W-1:0] cand_prio;
  logic              win_found;
  logic [ID_W-1:0]   win_id_d;
  logic [PRIO_W-1:0] win_lvl_d;
  logic              to_hit;

  // Next source index after base, wrapping at N_SRC (N_SRC need not be a power of 2).
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_SRC) s = s - N_SRC;
    return ID_W'(s);
  endfunction

  assign elig = sched_en_i ? (irq_src_i & irq_mask_i) : '0;

`ifdef INT_SCHED_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr_q;

  assign search_base = rr_ptr_q;

  // Rotate the tie-break start past the source that just completed service.
  // Timeouts leave the pointer where it is.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      rr_ptr_q <= '0;
    end else if (svc_done_q) begin
      rr_ptr_q <= wrap_add(svc_id_q, 1);
    end
  end
`else
  assign search_base = '0;
`endif

  // Priority search. It starts at search_base and a candidate replaces the
  // current best only when its priority is strictly higher, so the first
  // source visited wins a tie.
  always_comb begin
    win_found = 1'b0;
    win_id_d  = '0;
    win_lvl_d = '0;
    cand_id   = '0;
    cand_prio = '0;
    for (int k = 0; k < N_SRC; k++) begin
      cand_id   = wrap_add(search_base, k);
      cand_prio = irq_prio_i[int'(cand_id)*PRIO_W +: PRIO_W];
      if (elig[cand_id] && (!win_found || (cand_prio > win_lvl_d))) begin
        win_found = 1'b1;
        win_id_d  = cand_id;
        win_lvl_d = cand_prio;
      end
    end
  end

  // The counter starts at 0 on REQ entry, so it reads timeout_val-1 in the
  // last allowed REQ cycle.
  assign to_hit = (timeout_val_i != '0) && (cnt_q == (timeout_val_i - TO_W'(1)));

  // Handshake FSM. All outputs are registered here. svc_done and timeout_err
  // default low, so they last exactly one cycle.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      irq_out_q     <= 1'b0;
      irq_id_q      <= '0;
      irq_lvl_q     <= '0;
      busy_q        <= 1'b0;
      svc_done_q    <= 1'b0;
      svc_id_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      svc_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      if (!sched_en_i) begin
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        irq_out_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (elig != '0) begin
              state_q <= ST_ARB;
              busy_q  <= 1'b1;
            end
          end
          ST_ARB: begin
            if (win_found) begin
              irq_id_q  <= win_id_d;
              irq_lvl_q <= win_lvl_d;
              cnt_q     <= '0;
              irq_out_q <= 1'b1;
              state_q   <= ST_REQ;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
          ST_REQ: begin
            if (cnt_q != '1) cnt_q <= cnt_q + TO_W'(1);
            if (cpu_ack_i) begin
              irq_out_q <= 1'b0;
              state_q   <= ST_SERV;
            end else if (to_hit) begin
              irq_out_q     <= 1'b0;
              timeout_err_q <= 1'b1;
              busy_q        <= 1'b0;
              state_q       <= ST_IDLE;
            end
          end
          ST_SERV: begin
            if (cpu_eoi_i) begin
              svc_done_q <= 1'b1;
              svc_id_q   <= irq_id_q;
              busy_q     <= 1'b0;
              state_q    <= ST_IDLE;
            end
          end
          default: begin
            state_q   <= ST_IDLE;
            irq_out_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign irq_out_o     = irq_out_q;
  assign irq_id_o      = irq_id_q;
  assign irq_lvl_o     = irq_lvl_q;
  assign busy_o        = busy_q;
  assign svc_done_o    = svc_done_q;
  assign svc_id_o      = svc_id_q;
  assign timeout_err_o = timeout_err_q;

endmodule
